// File: rtl/nios_wallet_secure_ram_if.sv
// Avalon-MM slave bus plus zeroization control/status for the wallet secure RAM.
// Widths follow the RAM parameters so one interface type serves every instance.
interface nios_wallet_secure_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    zeroize;
  logic                    busy;
  logic                    zero_done;
  logic                    oor_err;

  // Handshake: a request (chipselect & (read|write)) is accepted on the rising edge
  // where waitrequest is low. waitrequest comes only from registered state, so the
  // master may look at it before presenting. Each accepted read (without write)
  // yields exactly one readdatavalid cycle, in order, a fixed latency later.
  modport master (
    output address, byteenable, chipselect, read, write, writedata, zeroize,
    input  readdata, readdatavalid, waitrequest, busy, zero_done, oor_err
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, zeroize,
    output readdata, readdatavalid, waitrequest, busy, zero_done, oor_err
  );
endinterface

// File: rtl/nios_wallet_secure_ram.sv
// Single-port on-chip RAM with byte lanes, 1- or 2-cycle read latency,
// out-of-range protection and a one-word-per-cycle hardware wipe engine.
module nios_wallet_secure_ram #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 13,
  parameter int DEPTH         = 6500,
  parameter int READ_LATENCY  = 1,
  parameter int ZERO_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios_wallet_secure_ram_if.slave   s_bus
);

  localparam int LP_NBE = DATA_WIDTH / 8;
  localparam int LP_IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH_EXT = DEPTH[ADDR_WIDTH:0];
  localparam logic [LP_IW-1:0]    LP_LAST      = LP_IW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam state_t LP_RST_STATE = (ZERO_ON_RESET != 0) ? ST_SWEEP : ST_IDLE;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LP_IW-1:0]   r_cnt;
  logic [LP_IW-1:0]   w_cnt_nxt;
  logic               r_zero_done;
  logic               w_zero_done_nxt;
  logic               w_sweep_entry;
  logic               r_oor;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_access;
  logic                  w_in_range;
  logic                  w_wr_en;
  logic                  w_rd_issue;
  logic                  w_oor_hit;
  logic [LP_IW-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  r_s1_v;
  logic [DATA_WIDTH-1:0] r_s1_d;
  logic                  w_rdv_out;
  logic [DATA_WIDTH-1:0] w_rdd_out;

  // ---------------- wipe FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= LP_RST_STATE;
      r_cnt       <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_zero_done <= w_zero_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_zero_done_nxt = 1'b0;
    w_sweep_entry   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_bus.zeroize) begin
          w_state_nxt   = ST_SWEEP;
          w_cnt_nxt     = '0;
          w_sweep_entry = 1'b1;
        end
      end
      ST_SWEEP: begin
        // zeroize is deliberately ignored here: a wipe never restarts or stretches
        if (r_cnt == LP_LAST) begin
          w_state_nxt     = ST_IDLE;
          w_zero_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- access decode ----------------
  assign w_busy     = (r_state == ST_SWEEP);
  assign w_access   = s_bus.chipselect & (s_bus.read | s_bus.write) & ~w_busy;
  assign w_in_range = ({1'b0, s_bus.address} < LP_DEPTH_EXT);
  assign w_wr_en    = w_access & s_bus.write & w_in_range;
  assign w_rd_issue = w_access & s_bus.read & ~s_bus.write;
  assign w_oor_hit  = w_access & ~w_in_range;
  assign w_idx      = s_bus.address[LP_IW-1:0];
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

  // Storage carries no reset: contents after reset are only trusted once a sweep ran.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < LP_NBE; b++) begin
        if (s_bus.byteenable[b]) begin
          r_mem[w_idx][8*b +: 8] <= s_bus.writedata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oor <= 1'b0;
    end else if (w_sweep_entry) begin
      r_oor <= 1'b0;
    end else if (w_oor_hit) begin
      r_oor <= 1'b1;
    end
  end

  // ---------------- read pipeline ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
    end else begin
      r_s1_v <= w_rd_issue;
      if (w_rd_issue) begin
        r_s1_d <= w_rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s2_v;
      logic [DATA_WIDTH-1:0] r_s2_d;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_s2_v <= 1'b0;
          r_s2_d <= '0;
        end else begin
          r_s2_v <= r_s1_v;
          if (r_s1_v) begin
            r_s2_d <= r_s1_d;
          end
        end
      end

      assign w_rdv_out = r_s2_v;
      assign w_rdd_out = r_s2_d;
    end else begin : g_lat1
      assign w_rdv_out = r_s1_v;
      assign w_rdd_out = r_s1_d;
    end
  endgenerate

  // ---------------- outputs ----------------
  assign s_bus.readdata      = w_rdd_out;
  assign s_bus.readdatavalid = w_rdv_out;
  assign s_bus.waitrequest   = w_busy;
  assign s_bus.busy          = w_busy;
  assign s_bus.zero_done     = r_zero_done;
  assign s_bus.oor_err       = r_oor;

endmodule
